// File: rtl/subway_pkg.sv
// Shared definitions for the subway runner path solver: cell and move
// encodings, lane count, FSM states and the lane-after-move helper.
package subway_pkg;

    localparam int LANES = 4;

    // Cell codes stored in the obstacle map
    localparam logic [1:0] CELL_ROAD  = 2'd0;
    localparam logic [1:0] CELL_LOW   = 2'd1;
    localparam logic [1:0] CELL_HIGH  = 2'd2;
    localparam logic [1:0] CELL_TRAIN = 2'd3;

    // Move codes; also used as bit positions in the legal-move mask
    localparam logic [1:0] MV_FWD   = 2'd0;
    localparam logic [1:0] MV_RIGHT = 2'd1;
    localparam logic [1:0] MV_LEFT  = 2'd2;
    localparam logic [1:0] MV_JUMP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SOLVE,
        ST_OUTPUT
    } state_t;

    // Lane reached after a move. Out-of-range results (right from lane 3,
    // left from lane 0) wrap, but those moves are always masked as illegal.
    function automatic logic [1:0] dest_lane(input logic [1:0] lane, input logic [1:0] mv);
        case (mv)
            MV_RIGHT: return lane + 2'd1;
            MV_LEFT:  return lane - 2'd1;
            default:  return lane;
        endcase
    endfunction

endpackage

// File: rtl/subway_move_legal.sv
// Combinational legality of the four moves from one cell into the next
// column. Bit m of legal corresponds to move code m.
module subway_move_legal
    import subway_pkg::*;
(
    input  logic [1:0]            cur_cell,
    input  logic [1:0]            lane,
    input  logic [LANES-1:0][1:0] nxt_cells,
    output logic [3:0]            legal
);

    logic [1:0] ahead;

    // Evaluate each move against the cell it lands on
    always_comb begin
        ahead          = nxt_cells[lane];
        legal          = '0;
        // Running forward is blocked by low obstacles and trains
        legal[MV_FWD]   = (ahead != CELL_LOW) && (ahead != CELL_TRAIN);
        // Jumping clears low obstacles but cannot land under a high one,
        // and cannot be started from underneath a high obstacle
        legal[MV_JUMP]  = (ahead != CELL_HIGH) && (ahead != CELL_TRAIN) &&
                          (cur_cell != CELL_HIGH);
        // Lane changes need the neighbouring lane to exist and be clear road
        legal[MV_RIGHT] = (lane != 2'(LANES-1)) && (nxt_cells[lane + 2'd1] == CELL_ROAD);
        legal[MV_LEFT]  = (lane != 2'd0) && (nxt_cells[lane - 2'd1] == CELL_ROAD);
    end

endmodule

// File: rtl/subway_path_solver.sv
// Subway runner path solver: loads a MAP_LEN x 4 obstacle map, computes
// per-cell reachability of the last column backwards one column per cycle,
// then walks forward from the start lane emitting one move per cycle.
module subway_path_solver
    import subway_pkg::*;
#(
    parameter int MAP_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] init,
    input  logic [1:0] in0,
    input  logic [1:0] in1,
    input  logic [1:0] in2,
    input  logic [1:0] in3,
    output logic       out_valid,
    output logic [1:0] out
);

    localparam int CW = $clog2(MAP_LEN);
    localparam logic [CW-1:0] LAST_COL  = CW'(MAP_LEN - 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(MAP_LEN - 2);

    state_t state_reg, state_next;

    // One counter serves as load beat, solve column and output step
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_plus1;
    logic [1:0]    lane_reg;
    logic          out_valid_reg;
    logic [1:0]    out_reg;

    // Obstacle map and reachability table (ok_mem[c][l]: last column
    // reachable from lane l at column c)
    logic [LANES-1:0][1:0] map_mem [MAP_LEN];
    logic [LANES-1:0]      ok_mem  [MAP_LEN];

    logic [LANES-1:0][1:0] cur_col;
    logic [LANES-1:0][1:0] nxt_col;
    logic [LANES-1:0]      ok_nxt;
    logic [LANES-1:0]      ok_col;
    logic                  load_beat;

    assign cnt_plus1 = cnt_reg + 1'b1;
    assign cur_col   = map_mem[cnt_reg];
    assign nxt_col   = map_mem[cnt_plus1];
    assign ok_nxt    = ok_mem[cnt_plus1];
    assign load_beat = in_valid && ((state_reg == ST_IDLE) || (state_reg == ST_LOAD));

    // Backward reachability: all lanes of one column evaluated in parallel
    for (genvar gi = 0; gi < LANES; gi++) begin : g_solve
        logic [3:0] legal;
        logic [3:0] reach;

        subway_move_legal u_legal (
            .cur_cell  (cur_col[gi]),
            .lane      (2'(gi)),
            .nxt_cells (nxt_col),
            .legal     (legal)
        );

        // Which moves from this lane land on a cell that can still finish
        always_comb begin
            reach = '0;
            for (int m = 0; m < 4; m++) begin
                reach[m] = ok_nxt[dest_lane(2'(gi), 2'(m))];
            end
        end

        assign ok_col[gi] = |(legal & reach);
    end

    // Forward walk: legality of moves from the runner's current cell
    logic [1:0] out_cur;
    logic [3:0] out_legal;
    logic [3:0] out_reach;
    logic [3:0] out_cand;
    logic [1:0] mv_sel;

    assign out_cur = cur_col[lane_reg];

    subway_move_legal u_out_legal (
        .cur_cell  (out_cur),
        .lane      (lane_reg),
        .nxt_cells (nxt_col),
        .legal     (out_legal)
    );

    // Pick the first surviving move in priority fwd, jump, right, left;
    // with no survivor, forward keeps the lane unchanged
    always_comb begin
        out_reach = '0;
        for (int m = 0; m < 4; m++) begin
            out_reach[m] = ok_nxt[dest_lane(lane_reg, 2'(m))];
        end
        out_cand = out_legal & out_reach;
        mv_sel   = MV_FWD;
        if (out_cand[MV_FWD]) begin
            mv_sel = MV_FWD;
        end else if (out_cand[MV_JUMP]) begin
            mv_sel = MV_JUMP;
        end else if (out_cand[MV_RIGHT]) begin
            mv_sel = MV_RIGHT;
        end else if (out_cand[MV_LEFT]) begin
            mv_sel = MV_LEFT;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                // The final beat is known from the counter, so solving can
                // start right after it without waiting a cycle for in_valid
                if (!in_valid || (cnt_reg == LAST_COL)) state_next = ST_SOLVE;
            end
            ST_SOLVE: begin
                if (cnt_reg == '0) state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (cnt_reg == LAST_STEP) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter, runner lane and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            lane_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_reg       <= MV_FWD;
        end else begin
            out_valid_reg <= 1'b0;
            out_reg       <= MV_FWD;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        lane_reg <= init;
                        cnt_reg  <= CW'(1);
                    end
                end
                ST_LOAD: begin
                    if (!in_valid || (cnt_reg == LAST_COL)) begin
                        cnt_reg <= LAST_STEP;
                    end else begin
                        cnt_reg <= cnt_plus1;
                    end
                end
                ST_SOLVE: begin
                    if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
                end
                ST_OUTPUT: begin
                    out_valid_reg <= 1'b1;
                    out_reg       <= mv_sel;
                    lane_reg      <= dest_lane(lane_reg, mv_sel);
                    cnt_reg       <= (cnt_reg == LAST_STEP) ? '0 : cnt_plus1;
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Map and reachability storage; contents are not reset because every
    // entry that is read gets rewritten by each pattern first
    always_ff @(posedge clk) begin
        if (load_beat) begin
            map_mem[cnt_reg] <= {in3, in2, in1, in0};
        end
        if ((state_reg == ST_IDLE) && in_valid) begin
            ok_mem[LAST_COL] <= '1;
        end
        if (state_reg == ST_SOLVE) begin
            ok_mem[cnt_reg] <= ok_col;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;

endmodule
